multicycle_ctl: RTL

Sequencing controller for the multi-cycle MIPS datapath: a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back cycles and drives every datapath enable and mux select. It supports R-type, lw, sw, beq and j, and stretches memory cycles with a ready handshake. It sits beside the shared datapath (PC, IR, MDR, A/B, ALUOut) and feeds the existing ALU control decoder via ALUOp.

---
 rtl/multicycle_ctl_pkg.sv | 60 ++++++
 rtl/multicycle_out_dec.sv | 98 +++++++++
 rtl/multicycle_ctl.sv | 104 ++++++++++
 3 files changed

// File: rtl/multicycle_ctl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcode constants (also used by the ALU control decoder), mux/ALUOp codes
// and the packed control-vector payload driven into the datapath.
package multicycle_ctl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full datapath control vector for one cycle.
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       inst_done;
    logic       halted;
  } ctl_t;

endpackage

// File: rtl/multicycle_out_dec.sv
// Combinational Moore decode of the controller state into the datapath
// control vector, with MemReady/Zero qualification and reset blanking.
//   state     : current controller state
//   mem_ready : memory completion this cycle
//   zero      : ALU zero flag (branch qualification)
//   rst       : forces every control to 0 while high
//   ctl_c     : decoded control vector
module multicycle_out_dec
  import multicycle_ctl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  input  logic   rst,
  output ctl_t   ctl_c
);

  logic pc_write;
  logic pc_write_cond;

  always_comb begin
    ctl_c         = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;

    unique case (state)
      S_FETCH: begin
        ctl_c.mem_read  = 1'b1;
        ctl_c.alu_src_b = SRCB_FOUR;
        ctl_c.alu_op    = ALUOP_ADD;
        ctl_c.pc_source = PCSRC_ALU;
        // IR and PC+4 commit only on the cycle the fetch completes.
        ctl_c.ir_write  = mem_ready;
        pc_write        = mem_ready;
      end
      S_DECODE: begin
        ctl_c.alu_src_b = SRCB_IMMSH;
        ctl_c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctl_c.mem_read = 1'b1;
        ctl_c.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.mem_to_reg = 1'b1;
        ctl_c.inst_done  = 1'b1;
      end
      S_MEMWR: begin
        ctl_c.mem_write = 1'b1;
        ctl_c.iord      = 1'b1;
        ctl_c.inst_done = mem_ready;
      end
      S_EXEC: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_B;
        ctl_c.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctl_c.reg_write = 1'b1;
        ctl_c.reg_dst   = 1'b1;
        ctl_c.inst_done = 1'b1;
      end
      S_BRANCH: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_B;
        ctl_c.alu_op    = ALUOP_SUB;
        ctl_c.pc_source = PCSRC_ALUOUT;
        ctl_c.inst_done = 1'b1;
        pc_write_cond   = 1'b1;
      end
      S_JUMP: begin
        ctl_c.pc_source = PCSRC_JUMP;
        ctl_c.inst_done = 1'b1;
        pc_write        = 1'b1;
      end
      S_TRAP: begin
        ctl_c.halted = 1'b1;
      end
      default: begin
        ctl_c = '0;
      end
    endcase

    ctl_c.pc_en = pc_write | (pc_write_cond & zero);

    // Reset blanks everything combinationally, ahead of the next edge.
    if (rst) begin
      ctl_c = '0;
    end
  end

endmodule

// File: rtl/multicycle_ctl.sv
// Multi-cycle MIPS sequencing controller (Moore FSM). Holds the state
// register, the opcode latched in DECODE and the next-state logic; the
// control vector comes from multicycle_out_dec.
//   CLK, RST           : clock, async active-high reset
//   Op, Zero, MemReady : opcode, ALU zero flag, memory handshake
//   PCEn .. PCSource   : datapath enables and mux selects
//   InstDone, Halted   : instruction-complete pulse, trap indication
//   State              : current state for debug
module multicycle_ctl
  import multicycle_ctl_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [5:0]         Op,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               InstDone,
  output logic               Halted,
  output logic [STATE_W-1:0] State
);

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] op_q;
  ctl_t            ctl_c;

  // State register plus the opcode captured on the DECODE exit edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= Op;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      // Only lw/sw reach here, so anything not sw is a load.
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  multicycle_out_dec u_out_dec (
    .state     (state_q),
    .mem_ready (MemReady),
    .zero      (Zero),
    .rst       (RST),
    .ctl_c     (ctl_c)
  );

  assign PCEn     = ctl_c.pc_en;
  assign IorD     = ctl_c.iord;
  assign MemRead  = ctl_c.mem_read;
  assign MemWrite = ctl_c.mem_write;
  assign IRWrite  = ctl_c.ir_write;
  assign MemtoReg = ctl_c.mem_to_reg;
  assign RegDst   = ctl_c.reg_dst;
  assign RegWrite = ctl_c.reg_write;
  assign ALUSrcA  = ctl_c.alu_src_a;
  assign ALUSrcB  = ctl_c.alu_src_b;
  assign ALUOp    = ctl_c.alu_op;
  assign PCSource = ctl_c.pc_source;
  assign InstDone = ctl_c.inst_done;
  assign Halted   = ctl_c.halted;
  assign State    = state_q;

endmodule
